// File: rtl/huff_stream_decoder.sv
// rtl/huff_stream_decoder.sv - byte-fed, flow-controlled prefix-code decoder emitting 3-bit symbols
// Unpacks bytes MSB-first into a one-bit-per-step code tree; frames end on in_last.
module huff_stream_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic [3:0]       in_nbits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sym,
    output logic             out_last,
    output logic             err,
    output logic [CNT_W-1:0] sym_count
);

    typedef enum logic [2:0] {
        ROOT  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S11   = 3'd3,
        S110  = 3'd4,
        S111  = 3'd5,
        S1111 = 3'd6
    } tree_t;

    logic [7:0]       shreg_q;
    logic [3:0]       cnt_q;
    logic             lastf_q;
    tree_t            tree_q;
    tree_t            tree_d;
    logic             out_valid_q;
    logic [2:0]       out_sym_q;
    logic             out_last_q;
    logic             err_q;
    logic [CNT_W-1:0] sym_count_q;
    logic [CNT_W-1:0] sym_count_d;

    logic       accept;
    logic       stall;
    logic       step;
    logic       cur_bit;
    logic       final_bit;
    logic       emit;
    logic [2:0] sym;
    logic [3:0] nbits_eff;
    logic       count_clear;

    assign in_ready  = (cnt_q == 4'd0);
    assign accept    = in_valid & in_ready;
    assign stall     = out_valid_q & ~out_ready;
    assign step      = (cnt_q != 4'd0) & ~stall;
    assign cur_bit   = shreg_q[7];
    assign final_bit = step & lastf_q & (cnt_q == 4'd1);

    // A last byte carries 1..8 meaningful bits; anything outside that range means a full byte.
    always_comb begin
        nbits_eff = 4'd8;
        if (in_last && (in_nbits != 4'd0) && (in_nbits <= 4'd8)) begin
            nbits_eff = in_nbits;
        end
    end

    always_comb begin
        tree_d = tree_q;
        emit   = 1'b0;
        sym    = 3'd0;
        case (tree_q)
            ROOT: begin
                if (!cur_bit) begin emit = 1'b1; sym = 3'd0; end
                else          tree_d = S1;
            end
            S1:    tree_d = cur_bit ? S11 : S10;
            S10: begin
                emit = 1'b1;
                sym  = cur_bit ? 3'd2 : 3'd1;
            end
            S11:   tree_d = cur_bit ? S111 : S110;
            S110: begin
                emit = 1'b1;
                sym  = cur_bit ? 3'd4 : 3'd3;
            end
            S111: begin
                if (!cur_bit) begin emit = 1'b1; sym = 3'd5; end
                else          tree_d = S1111;
            end
            S1111: begin
                emit = 1'b1;
                sym  = cur_bit ? 3'd7 : 3'd6;
            end
            default: tree_d = ROOT;
        endcase
    end

    // Clear takes priority over the increment of a same-cycle emit, so that case lands on 1.
    assign count_clear = (out_valid_q & out_ready & out_last_q) | err_q;

    always_comb begin
        sym_count_d = sym_count_q;
        if (count_clear) begin
            sym_count_d = '0;
        end
        if (step && emit && !(&sym_count_d)) begin
            sym_count_d = sym_count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q     <= 8'd0;
            cnt_q       <= 4'd0;
            lastf_q     <= 1'b0;
            tree_q      <= ROOT;
            out_valid_q <= 1'b0;
            out_sym_q   <= 3'd0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            sym_count_q <= '0;
        end else begin
            if (accept) begin
                shreg_q <= in_data;
                cnt_q   <= nbits_eff;
                lastf_q <= in_last;
            end else if (step) begin
                shreg_q <= {shreg_q[6:0], 1'b0};
                cnt_q   <= cnt_q - 4'd1;
            end

            // A frame ending mid-codeword abandons the partial code.
            if (step) begin
                tree_q <= (emit || final_bit) ? ROOT : tree_d;
            end

            if (step && emit) begin
                out_valid_q <= 1'b1;
                out_sym_q   <= sym;
                out_last_q  <= final_bit;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            err_q       <= final_bit & ~emit;
            sym_count_q <= sym_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_last  = out_last_q;
    assign err       = err_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_huff_stream_decoder.sv
// tb/tb_huff_stream_decoder.sv - directed scenario bench for huff_stream_decoder
module tb_huff_stream_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic [3:0]  in_nbits = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_sym;
    logic        out_last;
    logic        err;
    logic [15:0] sym_count;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    logic [2:0]  sym_q[$];
    logic        last_q[$];
    logic [15:0] snap_q[$];

    huff_stream_decoder #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_nbits(in_nbits),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .out_last(out_last), .err(err), .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                sym_q.push_back(out_sym);
                last_q.push_back(out_last);
                snap_q.push_back(sym_count);
            end
            if (err) err_cnt = err_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        sym_q.delete(); last_q.delete(); snap_q.delete(); err_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic [3:0] nb);
        int n = 0;
        in_data = d; in_last = l; in_nbits = nb; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL send_byte: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_syms(input int n, input int budget, input string name);
        int k = 0;
        while (sym_q.size() < n && k < budget) begin @(posedge clk); #1; k++; end
        tests++;
        if (sym_q.size() < n) begin
            fails++;
            $display("FAIL %s_timeout: got %0d symbols expected %0d", name, sym_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; #3;
        tests++;
        if ({out_valid, out_sym, out_last, err} !== 6'd0 || sym_count !== 16'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b s=%0d l=%b e=%b c=%0d r=%b expected 0,0,0,0,0,1",
                     out_valid, out_sym, out_last, err, sym_count, in_ready);
        end
        do_reset();
    endtask

    task automatic test_zeros();
        do_reset();
        send_byte(8'h00, 1'b0, 4'd8);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL zeros_accept_cycle: got out_valid=%b expected 0", out_valid); end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_sym !== 3'd0) begin
            fails++; $display("FAIL zeros_first_latency: got v=%b s=%0d expected 1,0", out_valid, out_sym);
        end
        wait_syms(8, 40, "zeros");
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (i >= sym_q.size() || sym_q[i] !== 3'd0 || last_q[i] !== 1'b0) begin
                fails++; $display("FAIL zeros_sym%0d: got wrong or missing symbol expected 0 last 0", i);
            end
        end
        tests++;
        if (sym_count !== 16'd8 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL zeros_end: got c=%0d r=%b v=%b expected 8,1,0", sym_count, in_ready, out_valid);
        end
    endtask

    task automatic test_last_frame(input logic [3:0] nb, input string name);
        logic [2:0] exp_s[6];
        exp_s = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        do_reset();
        send_byte(8'hA0, 1'b1, nb);
        wait_syms(6, 40, name);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (i >= sym_q.size() || sym_q[i] !== exp_s[i] || last_q[i] !== (i == 5)) begin
                fails++; $display("FAIL %s_sym%0d: got wrong or missing expected sym %0d last %0d", name, i, exp_s[i], (i == 5));
            end
        end
        tests++;
        if (snap_q.size() < 6 || snap_q[5] !== 16'd6) begin
            fails++; $display("FAIL %s_count_at_last: got wrong count expected 6", name);
        end
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (sym_count !== 16'd0 || sym_q.size() != 6) begin
            fails++; $display("FAIL %s_count_clear: got c=%0d n=%0d expected 0,6", name, sym_count, sym_q.size());
        end
    endtask

    task automatic test_cross_byte();
        logic [2:0] exp_s[8];
        exp_s = '{3'd6, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        do_reset();
        send_byte(8'hF7, 1'b0, 4'd8);
        send_byte(8'hC0, 1'b1, 4'd8);
        wait_syms(8, 60, "cross");
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (i >= sym_q.size() || sym_q[i] !== exp_s[i] || last_q[i] !== (i == 7)) begin
                fails++; $display("FAIL cross_sym%0d: got wrong or missing expected sym %0d last %0d", i, exp_s[i], (i == 7));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h00, 1'b0, 4'd8);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || out_sym !== 3'd0 || dut.cnt_q !== 4'd7 || sym_count !== 16'd1 || in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d: got v=%b s=%0d cnt=%0d c=%0d r=%b expected 1,0,7,1,0",
                                  i, out_valid, out_sym, dut.cnt_q, sym_count, in_ready);
            end
        end
        out_ready = 1'b1;
        wait_syms(8, 40, "bp");
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (sym_q.size() != 8 || sym_count !== 16'd8) begin
            fails++; $display("FAIL bp_total: got n=%0d c=%0d expected 8,8", sym_q.size(), sym_count);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (i >= sym_q.size() || sym_q[i] !== 3'd0) begin fails++; $display("FAIL bp_sym%0d: got wrong or missing expected 0", i); end
        end
    endtask

    task automatic test_truncated();
        do_reset();
        send_byte(8'hC0, 1'b1, 4'd2);
        @(posedge clk); #1;
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL trunc_err_early: got %b expected 0", err); end
        @(posedge clk); #1;
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL trunc_err_pulse: got %b expected 1", err); end
        @(posedge clk); #1;
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL trunc_err_width: got %b expected 0", err); end
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (err_cnt != 1 || sym_q.size() != 0 || dut.tree_q !== 3'd0 || sym_count !== 16'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL trunc_state: got errs=%0d n=%0d tree=%0d c=%0d v=%b expected 1,0,0,0,0",
                              err_cnt, sym_q.size(), dut.tree_q, sym_count, out_valid);
        end
        send_byte(8'h00, 1'b0, 4'd8);
        wait_syms(8, 40, "trunc_next");
        tests++;
        if (sym_q.size() < 8 || sym_q[0] !== 3'd0 || sym_q[7] !== 3'd0 || sym_count !== 16'd8) begin
            fails++; $display("FAIL trunc_next: got n=%0d c=%0d expected 8 zeros and count 8", sym_q.size(), sym_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_byte(8'h30, 1'b0, 4'd8);
        repeat (4) begin @(posedge clk); #1; end
        tests++;
        if (dut.cnt_q !== 4'd4 || dut.tree_q !== 3'd3 || sym_count !== 16'd2) begin
            fails++; $display("FAIL ar_pre: got cnt=%0d tree=%0d c=%0d expected 4,3,2", dut.cnt_q, dut.tree_q, sym_count);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({out_valid, out_sym, out_last, err} !== 6'd0 || sym_count !== 16'd0 || in_ready !== 1'b1 || dut.tree_q !== 3'd0) begin
            fails++; $display("FAIL ar_immediate: got v=%b s=%0d l=%b e=%b c=%0d r=%b expected 0,0,0,0,0,1",
                              out_valid, out_sym, out_last, err, sym_count, in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        sym_q.delete(); last_q.delete(); snap_q.delete(); err_cnt = 0;
        send_byte(8'h80, 1'b1, 4'd3);
        wait_syms(1, 30, "ar");
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (sym_q.size() != 1 || sym_q[0] !== 3'd1 || last_q[0] !== 1'b1 || sym_count !== 16'd0 || err_cnt != 0) begin
            fails++; $display("FAIL ar_decode: got n=%0d c=%0d errs=%0d expected one symbol 1 with last, count 0, no err",
                              sym_q.size(), sym_count, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        send_byte(8'hA0, 1'b1, 4'd3);
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (out_valid !== 1'b1 || out_sym !== 3'd2 || out_last !== 1'b1 || in_ready !== 1'b1 || sym_count !== 16'd1) begin
            fails++; $display("FAIL b2b_held: got v=%b s=%0d l=%b r=%b c=%0d expected 1,2,1,1,1",
                              out_valid, out_sym, out_last, in_ready, sym_count);
        end
        send_byte(8'h00, 1'b0, 4'd8);
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (sym_count !== 16'd1 || out_valid !== 1'b1 || out_sym !== 3'd0 || out_last !== 1'b0) begin
            fails++; $display("FAIL b2b_clear_and_emit: got c=%0d v=%b s=%0d l=%b expected 1,1,0,0",
                              sym_count, out_valid, out_sym, out_last);
        end
        wait_syms(9, 40, "b2b");
        tests++;
        if (sym_q.size() < 9 || sym_q[0] !== 3'd2 || last_q[0] !== 1'b1 || sym_q[8] !== 3'd0 || sym_count !== 16'd8) begin
            fails++; $display("FAIL b2b_stream: got n=%0d c=%0d expected 2(last) then 8 zeros, count 8", sym_q.size(), sym_count);
        end
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_last_frame(4'd8, "last8");
        test_last_frame(4'd0, "last0");
        test_cross_byte();
        test_backpressure();
        test_truncated();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
